// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction read in flight, and feeds the IF/ID register.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iStall,
    input  logic        iFlush,
    input  logic [31:0] iBrTarget,
    output logic        oReq,
    output logic [31:0] oReqAddr,
    input  logic        iReqReady,
    input  logic        iRspValid,
    input  logic [31:0] iRspData,
    output logic        oValid,
    output logic [31:0] oPC,
    output logic [31:0] oInstr,
    output logic        oBusy,
    output logic        oMisalign,
    output logic [1:0]  oDbgState
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        buf_valid_q, buf_valid_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        misalign_q, misalign_d;
    logic        req;
    logic        rsp_fire;
    logic        misalign_set;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target       = iBrTarget;
    assign misalign_set = |iBrTarget[1:0];
`else
    assign target       = {iBrTarget[31:2], 2'b00};
    assign misalign_set = 1'b0;
`endif

    // Request handshake: a request transfers on a cycle where oReq && iReqReady; oReq and
    // oReqAddr hold until then. A response transfers on any cycle with iRspValid in WAIT/DISCARD.
    assign rsp_fire = (state_q == S_WAIT) && iRspValid;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:     if (req && iReqReady) state_d = S_WAIT;
            S_WAIT:    if (iRspValid) state_d = S_REQ;
                       else if (iFlush) state_d = S_DISCARD;
            // The dropped response is the only one outstanding, so its arrival always frees us.
            S_DISCARD: if (iRspValid) state_d = S_REQ;
            default:   state_d = S_REQ;
        endcase
    end

    always_comb begin
        req       = nRst && (state_q == S_REQ) && !buf_valid_q && !iFlush && !misalign_q;
        oReq      = req;
        oReqAddr  = pc_q;
        oBusy     = !buf_valid_q && !rsp_fire;
        oValid    = out_valid_q;
        oPC       = out_pc_q;
        oInstr    = out_instr_q;
        oMisalign = misalign_q;
        oDbgState = state_q;
    end

    always_comb begin
        pc_d        = pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_valid_d = buf_valid_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        misalign_d  = misalign_q;
        if (iFlush) begin
            pc_d        = target;
            buf_valid_d = 1'b0;
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            misalign_d  = misalign_set;
        end else begin
            if (rsp_fire) pc_d = pc_q + 32'd4;
            if (!iStall) begin
                if (buf_valid_q) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = buf_pc_q;
                    out_instr_d = buf_instr_q;
                    buf_valid_d = 1'b0;
                end else if (rsp_fire) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = pc_q;
                    out_instr_d = iRspData;
                end else begin
                    out_valid_d = 1'b0;
                    out_instr_d = NOP_INSTR;
                end
            end
            // A response that cannot go straight to IF/ID parks in the skid buffer.
            if (rsp_fire && (iStall || buf_valid_q)) begin
                buf_pc_d    = pc_q;
                buf_instr_d = iRspData;
                buf_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            pc_q        <= RESET_PC;
            buf_pc_q    <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            buf_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_instr_q <= NOP_INSTR;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_valid_q <= buf_valid_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            misalign_q  <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a one-outstanding memory model, request/output scoreboards and timing spot checks.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        iClk = 1'b0;
    logic        nRst = 1'b0;
    logic        iStall = 1'b0;
    logic        iFlush = 1'b0;
    logic [31:0] iBrTarget = '0;
    logic        oReq;
    logic [31:0] oReqAddr;
    logic        iReqReady;
    logic        iRspValid;
    logic [31:0] iRspData;
    logic        oValid;
    logic [31:0] oPC;
    logic [31:0] oInstr;
    logic        oBusy;
    logic        oMisalign;
    logic [1:0]  oDbgState;

    int          n_tests = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;
    int          budget_lim = 0;
    int          rsp_lat = 1;
    int          mem_cnt = 0;
    logic        acc_seen = 1'b0;
    logic [31:0] acc_addr = '0;
    logic        rsp_seen = 1'b0;
    logic        stall_prev = 1'b0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_rsp_v = 1'b0;
    logic [31:0] mem_data = '0;
    logic        inj_rsp_v = 1'b0;

    logic [31:0] exp_req_q[$];
    logic [63:0] exp_out_q[$];

    assign iReqReady = (acc_cnt < budget_lim);
    assign iRspValid = mem_rsp_v | inj_rsp_v;
    assign iRspData  = mem_data;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .iClk(iClk), .nRst(nRst), .iStall(iStall), .iFlush(iFlush), .iBrTarget(iBrTarget),
        .oReq(oReq), .oReqAddr(oReqAddr), .iReqReady(iReqReady), .iRspValid(iRspValid),
        .iRspData(iRspData), .oValid(oValid), .oPC(oPC), .oInstr(oInstr), .oBusy(oBusy),
        .oMisalign(oMisalign), .oDbgState(oDbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 iClk = ~iClk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    always @(posedge iClk) begin
        acc_seen   <= nRst && oReq && iReqReady;
        acc_addr   <= oReqAddr;
        rsp_seen   <= iRspValid;
        stall_prev <= iStall;
        if (nRst && oReq && iReqReady) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge iClk) begin
        if (!nRst) begin
            mem_busy  = 1'b0;
            mem_rsp_v = 1'b0;
        end else begin
            if (rsp_seen) mem_busy = 1'b0;
            if (acc_seen) begin
                mem_busy = 1'b1;
                mem_addr = acc_addr;
                mem_cnt  = rsp_lat;
            end
            mem_rsp_v = 1'b0;
            if (mem_busy) begin
                if (mem_cnt <= 1) begin
                    mem_rsp_v = 1'b1;
                    mem_data  = mem_word(mem_addr);
                end else begin
                    mem_cnt--;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge iClk) begin
        logic [63:0] e;
        #2;
        if (nRst && oReq && iReqReady) begin
            if (exp_req_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_unexpected: got addr %h, none expected", oReqAddr);
            end else begin
                check("req_addr", oReqAddr, exp_req_q.pop_front());
            end
        end
        if (nRst && oValid && !stall_prev) begin
            if (exp_out_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got pc %h instr %h, none expected", oPC, oInstr);
            end else begin
                e = exp_out_q.pop_front();
                check("out_pc", oPC, e[63:32]);
                check("out_instr", oInstr, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge iClk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_req_q.push_back(a);
        exp_out_q.push_back({a, mem_word(a)});
    endtask

    task automatic check_reset();
        check("rst_oReq", oReq, 0);
        check("rst_oValid", oValid, 0);
        check("rst_oPC", oPC, RST_PC);
        check("rst_oInstr", oInstr, NOP);
        check("rst_oBusy", oBusy, 1);
        check("rst_oMisalign", oMisalign, 0);
        check("rst_state", oDbgState, 0);
    endtask

    task automatic do_reset(input int budget);
        nRst = 1'b0;
        #1;
        check_reset();
        step();
        step();
        check_reset();
        budget_lim = acc_cnt + budget;
        nRst = 1'b1;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_req_q.size() != 0 || exp_out_q.size() != 0) && k < 60) begin
            step();
            k++;
        end
        step();
        step();
        check("drain_req_left", 32'(exp_req_q.size()), 0);
        check("drain_out_left", 32'(exp_out_q.size()), 0);
        exp_req_q.delete();
        exp_out_q.delete();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [5:0] pulse_pat;
        pulse_pat = 6'b101010;
        step();

        // Sustained fetch: one instruction every second cycle.
        push_fetch(32'h100);
        push_fetch(32'h104);
        push_fetch(32'h108);
        do_reset(3);
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t1_valid_pulse", oValid, 32'(pulse_pat[i-1]));
        end
        drain();

        // Stall while the response for 104 arrives.
        push_fetch(32'h100);
        push_fetch(32'h104);
        push_fetch(32'h108);
        do_reset(3);
        step();
        step();
        check("t2_req_104", oReqAddr, 32'h104);
        step();
        iStall = 1'b1;
        step();
        check("t2_busy_buf", oBusy, 0);
        check("t2_valid_held", oValid, 0);
        for (int i = 0; i < 3; i++) begin
            check("t2_no_req", oReq, 0);
            check("t2_pc_held", oPC, 32'h100);
            step();
        end
        iStall = 1'b0;
        step();
        check("t2_rel_valid", oValid, 1);
        check("t2_rel_pc", oPC, 32'h104);
        check("t2_rel_req", oReq, 1);
        check("t2_rel_addr", oReqAddr, 32'h108);
        drain();

        // Reset while a request is in flight, then a stray response in REQ.
        push_req(32'h10C);
        budget_lim = acc_cnt + 1;
        step();
        check("mid_wait", oDbgState, 1);
        do_reset(0);
        step();
        inj_rsp_v = 1'b1;
        #1;
        check("stray_busy", oBusy, 1);
        check("stray_state", oDbgState, 0);
        step();
        inj_rsp_v = 1'b0;
        check("stray_no_valid", oValid, 0);
        check("stray_still_req", oDbgState, 0);
        step();

        // Flush while waiting; the late response must be discarded.
        push_fetch(32'h100);
        push_fetch(32'h104);
        push_req(32'h108);
        push_fetch(32'h200);
        do_reset(4);
        step();
        step();
        step();
        step();
        rsp_lat = 2;
        step();
        check("t3_wait", oDbgState, 1);
        iFlush = 1'b1;
        iBrTarget = 32'h200;
        #1;
        check("t3_flush_noreq", oReq, 0);
        step();
        iFlush = 1'b0;
        rsp_lat = 1;
        check("t3_discard", oDbgState, 2);
        check("t3_discard_noreq", oReq, 0);
        check("t3_discard_busy", oBusy, 1);
        check("t3_bubble", oValid, 0);
        step();
        check("t3_back_req", oDbgState, 0);
        check("t3_req", oReq, 1);
        check("t3_req_addr", oReqAddr, 32'h200);
        drain();

        // Flush in the same cycle as the response.
        push_req(32'h204);
        push_fetch(32'h300);
        budget_lim = acc_cnt + 2;
        step();
        check("t4_wait", oDbgState, 1);
        iFlush = 1'b1;
        iBrTarget = 32'h300;
        #1;
        check("t4_busy_rsp", oBusy, 0);
        check("t4_flush_noreq", oReq, 0);
        step();
        iFlush = 1'b0;
        #1;
        check("t4_no_discard", oDbgState, 0);
        check("t4_req", oReq, 1);
        check("t4_req_addr", oReqAddr, 32'h300);
        check("t4_bubble", oValid, 0);
        drain();

        // PC wrap at the top of the address space.
        iFlush = 1'b1;
        iBrTarget = 32'hFFFF_FFFC;
        #1;
        check("t5_flush_noreq", oReq, 0);
        push_fetch(32'hFFFF_FFFC);
        push_fetch(32'h0000_0000);
        step();
        iFlush = 1'b0;
        budget_lim = acc_cnt + 2;
        drain();

        // Redirect to a misaligned target.
`ifdef FETCH_MISALIGN_CHK_EN
        budget_lim = acc_cnt + 1;
        iFlush = 1'b1;
        iBrTarget = 32'h202;
        step();
        iFlush = 1'b0;
        #1;
        check("t6_misalign", oMisalign, 1);
        check("t6_noreq", oReq, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_misalign_sticky", oMisalign, 1);
            check("t6_noreq_hold", oReq, 0);
            check("t6_bubble", oValid, 0);
        end
        push_fetch(32'h400);
        iFlush = 1'b1;
        iBrTarget = 32'h400;
        step();
        iFlush = 1'b0;
        #1;
        check("t6_clear", oMisalign, 0);
        check("t6_req", oReq, 1);
        check("t6_req_addr", oReqAddr, 32'h400);
        drain();
`else
        iFlush = 1'b1;
        iBrTarget = 32'h202;
        step();
        iFlush = 1'b0;
        push_fetch(32'h200);
        budget_lim = acc_cnt + 1;
        #1;
        check("t6_no_misalign", oMisalign, 0);
        check("t6_req", oReq, 1);
        check("t6_req_addr", oReqAddr, 32'h200);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
